// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port memory arbiter: FSM state encoding,
// requester port ids and latency-counter width.
package mem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 2-way picker between instruction and data requesters.
// Build option MEM_ARB_DPRIO_EN: port D always wins a tie (else round-robin).
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic any,
  output logic win_id
);

  // Winner selection; a tie goes to the port that was not granted last time.
  always_comb begin
    any    = i_req | d_req;
    win_id = PORT_I;
    if (i_req && d_req) begin
`ifdef MEM_ARB_DPRIO_EN
      win_id = PORT_D;
`else
      win_id = ~last_grant;
`endif
    end else if (d_req) begin
      win_id = PORT_D;
    end else begin
      win_id = PORT_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between CPU fetch (I) and
// load/store (D) ports. Tie-break policy selected by MEM_ARB_DPRIO_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant
);

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  arb_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 grant_q, grant_d;
  logic                 last_grant_q, last_grant_d;
  logic                 busy_q, busy_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic [DW-1:0]        mem_wdata_q, mem_wdata_d;
  logic                 i_ack_q, i_ack_d;
  logic                 d_ack_q, d_ack_d;
  logic [DW-1:0]        i_rdata_q, i_rdata_d;
  logic [DW-1:0]        d_rdata_q, d_rdata_d;
  logic                 pick_any_s;
  logic                 pick_win_s;

  mem_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant_q),
    .any        (pick_any_s),
    .win_id     (pick_win_s)
  );

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      cnt_q        <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      busy_q       <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Next-state logic: grant, one-cycle strobe, MEM_LAT wait cycles, ack cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      ARB_IDLE: begin
        if (pick_any_s) begin
          grant_d      = pick_win_s;
          last_grant_d = pick_win_s;
          mem_en_d     = 1'b1;
          cnt_d        = LAT_CNT;
          state_d      = ARB_ISSUE;
          if (pick_win_s == PORT_D) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
          end
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_ISSUE: begin
        // Counter keeps MEM_LAT here so WAIT spans exactly MEM_LAT cycles.
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ARB_DONE;
          cnt_d   = '0;
          if (grant_q == PORT_D) begin
            d_ack_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end else begin
            i_ack_d = 1'b1;
            if (!mem_we_q) begin
              i_rdata_d = mem_rdata;
            end else begin
              i_rdata_d = i_rdata_q;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    busy_d = (state_d != ARB_IDLE);
  end

  assign i_ack     = i_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign grant     = grant_q;

endmodule
